fir_out_buffer: RTL and testbench

//  Elastic sample buffer directly downstream of the FIR core (core_m); consumes its
//  m_axis_data_* stream of 16-bit signed audio samples.
//  The FIR master has no tready, so this block absorbs bursts and presents a

---
 rtl/fir_out_buffer.sv | 165 ++++++++++++++++
 tb/tb_fir_out_buffer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_out_buffer.sv
// ---------------------------------------------------------------------------
// fir_out_buffer
//
// Elastic sample buffer that sits directly after the FIR core. The FIR master
// has no tready, so this block absorbs bursts in a small FIFO and presents a
// back-pressurable AXI-Stream master to the next stage. When the FIFO is full
// and nothing drains in the same cycle, the incoming sample is dropped and the
// sticky overflow flag is raised, so samples are never lost silently.
//
// The output is first-word-fall-through. A sample written at edge N is visible
// on m_axis in the following cycle. Samples pass through bit-exact.
//
// Optional feature macro: FIR_OUT_PEAK_EN
//   Defined   : peak_abs tracks max |sample| over the accepted inputs. The most
//               negative code saturates to the most positive one. peak_clr
//               zeroes the peak and wins over a same-cycle update.
//   Undefined : peak_abs is tied to 0 and peak_clr is ignored.
//
// Parameters
//   DATA_W  sample width (two's complement)
//   DEPTH   FIFO entries, power of two, >= 2
//
// Ports
//   aclk                in   clock, rising edge
//   areset              in   synchronous reset, active-high
//   s_axis_data_tvalid  in   sample valid from the FIR core
//   s_axis_data_tdata   in   sample from the FIR core
//   s_axis_data_tready  out  space available (informational only)
//   m_axis_data_tvalid  out  output sample valid (FIFO not empty)
//   m_axis_data_tready  in   downstream accepts
//   m_axis_data_tdata   out  output sample (0 while not valid)
//   fill_level          out  entries stored, 0..DEPTH
//   overflow            out  sticky flag: an input sample was dropped
//   peak_clr            in   clear the peak register
//   peak_abs            out  peak absolute value of the accepted samples
// ---------------------------------------------------------------------------
module fir_out_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      s_axis_data_tvalid,
  input  logic [DATA_W-1:0]         s_axis_data_tdata,
  output logic                      s_axis_data_tready,
  output logic                      m_axis_data_tvalid,
  input  logic                      m_axis_data_tready,
  output logic [DATA_W-1:0]         m_axis_data_tdata,
  output logic [$clog2(DEPTH):0]    fill_level,
  output logic                      overflow,
  input  logic                      peak_clr,
  output logic [DATA_W-1:0]         peak_abs
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Storage and control state
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic full;
  logic rd_en;
  logic wr_en;
  logic drop;

  // Handshake decode and next-state computation
  always_comb begin
    full  = (cnt_q == CNT_W'(DEPTH));
    rd_en = (cnt_q != '0) & m_axis_data_tready;
    // A full FIFO that is being read in this cycle still accepts the new
    // sample: the slot freed by the read is reused in the same edge.
    wr_en = s_axis_data_tvalid & (~full | rd_en);
    drop  = s_axis_data_tvalid & full & ~rd_en;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q | drop;

    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control registers
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Sample storage: data only. Stale entries are never visible because the
  // count gates the output. When the FIFO is not empty, wr_ptr never equals
  // rd_ptr except when it is full, and in that case a write only occurs
  // together with a read of that same slot.
  always_ff @(posedge aclk) begin
    if (wr_en) mem_q[wr_ptr_q] <= s_axis_data_tdata;
  end

  // Output stage
  always_comb begin
    m_axis_data_tvalid = (cnt_q != '0);
    m_axis_data_tdata  = m_axis_data_tvalid ? mem_q[rd_ptr_q] : '0;
    s_axis_data_tready = ~full | m_axis_data_tready;
    fill_level         = cnt_q;
    overflow           = ovf_q;
  end

`ifdef FIR_OUT_PEAK_EN
  // |x| with the most negative code saturated to the most positive one.
  function automatic logic [DATA_W-1:0] sat_abs(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] min_val;
    logic signed [DATA_W-1:0] neg;
    min_val = {1'b1, {(DATA_W-1){1'b0}}};
    if (x == min_val) begin
      sat_abs = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (x < 0) begin
      neg     = -x;
      sat_abs = neg;
    end else begin
      sat_abs = x;
    end
  endfunction

  logic [DATA_W-1:0] peak_q, peak_d;
  logic [DATA_W-1:0] in_abs;

  // Peak tracker on accepted samples
  always_comb begin
    in_abs = sat_abs(s_axis_data_tdata);
    peak_d = peak_q;
    if (wr_en && (in_abs > peak_q)) peak_d = in_abs;
    if (peak_clr) peak_d = '0;
  end

  always_ff @(posedge aclk) begin
    if (areset) peak_q <= '0;
    else        peak_q <= peak_d;
  end

  assign peak_abs = peak_q;
`else
  logic unused_peak_clr;
  assign unused_peak_clr = peak_clr;
  assign peak_abs        = '0;
`endif

endmodule

// File: tb/tb_fir_out_buffer.sv
// ---------------------------------------------------------------------------
// tb_fir_out_buffer
//
// Testbench for fir_out_buffer. A driver task applies one cycle of stimulus.
// It advances a queue-based reference model (stored samples, overflow flag and
// running peak) and pushes each accepted sample onto a scoreboard queue. A
// separate monitor pops that queue whenever the DUT completes an output
// handshake and compares the data. The run covers directed scenarios followed
// by randomized traffic.
// ---------------------------------------------------------------------------
module tb_fir_out_buffer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              aclk = 1'b0;
  logic              areset;
  logic              s_tvalid;
  logic [DATA_W-1:0] s_tdata;
  logic              s_tready;
  logic              m_tvalid;
  logic              m_tready;
  logic [DATA_W-1:0] m_tdata;
  logic [CNT_W-1:0]  fill_level;
  logic              overflow;
  logic              peak_clr;
  logic [DATA_W-1:0] peak_abs;

  fir_out_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .aclk               (aclk),
    .areset             (areset),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tdata  (s_tdata),
    .s_axis_data_tready (s_tready),
    .m_axis_data_tvalid (m_tvalid),
    .m_axis_data_tready (m_tready),
    .m_axis_data_tdata  (m_tdata),
    .fill_level         (fill_level),
    .overflow           (overflow),
    .peak_clr           (peak_clr),
    .peak_abs           (peak_abs)
  );

  always #5 aclk = ~aclk;

  // Reference model state
  logic [DATA_W-1:0] sb_q[$];   // accepted samples not yet consumed, oldest first
  int                mcnt  = 0;
  bit                movf  = 1'b0;
  int                mpeak = 0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int abs_sat(input logic [DATA_W-1:0] d);
    int v;
    v = int'($signed(d));
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  // One clock cycle: check the registered state left by the previous edge,
  // apply new inputs, then advance the model to what the next edge produces.
  task automatic step(input bit rst, input bit tv, input logic [DATA_W-1:0] d,
                      input bit tr, input bit clr);
    bit rd, wr;
    @(posedge aclk);
    #1;
    chk("fill_level", 32'(fill_level), 32'(mcnt));
    chk("overflow",   32'(overflow),   32'(movf));
    chk("m_tvalid",   32'(m_tvalid),   32'(mcnt != 0));
    if (mcnt != 0 && sb_q.size() > 0) chk("m_tdata_head", 32'(m_tdata), 32'(sb_q[0]));
    else if (mcnt == 0)               chk("m_tdata_idle", 32'(m_tdata), 32'd0);
    chk("peak_abs",   32'(peak_abs),   32'(mpeak));

    areset   = rst;
    s_tvalid = tv;
    s_tdata  = d;
    m_tready = tr;
    peak_clr = clr;
    #1;
    chk("s_tready", 32'(s_tready), 32'((mcnt < DEPTH) || tr));

    if (rst) begin
      sb_q.delete();
      mcnt  = 0;
      movf  = 1'b0;
      mpeak = 0;
    end else begin
      rd = (mcnt > 0) && tr;
      wr = tv && ((mcnt < DEPTH) || rd);
      if (wr) sb_q.push_back(d);
      if (tv && !wr) movf = 1'b1;
      mcnt = mcnt + int'(wr) - int'(rd);
`ifdef FIR_OUT_PEAK_EN
      if (clr) mpeak = 0;
      else if (wr && abs_sat(d) > mpeak) mpeak = abs_sat(d);
`endif
    end
  endtask

  // Monitor: every completed output handshake consumes the oldest accepted sample.
  initial begin
    forever begin
      @(negedge aclk);
      if (!areset && m_tvalid && m_tready) begin
        if (sb_q.size() == 0) begin
          chk("m_tdata_unexpected", 32'(m_tdata), 32'hFFFF_FFFF);
        end else begin
          chk("m_tdata_out", 32'(m_tdata), 32'(sb_q.pop_front()));
        end
      end
    end
  end

  initial begin
    areset   = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b0;
    peak_clr = 1'b0;

    // Reset state: the first step checks everything against the cleared model.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Three samples held back, then drained in order.
    step(0, 1, 16'h1234, 0, 0);
    step(0, 1, 16'hFFFB, 0, 0);
    step(0, 1, 16'h0007, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t2_fill",  32'(fill_level), 32'd3);
    chk("t2_head",  32'(m_tdata),    32'h1234);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("t2_empty_fill",  32'(fill_level), 32'd0);
    chk("t2_empty_valid", 32'(m_tvalid),   32'd0);

    // Fill completely, drop one sample, drain.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 16'(i), 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t3_full_fill",   32'(fill_level), 32'(DEPTH));
    chk("t3_full_tready", 32'(s_tready),   32'd0);
    step(0, 1, 16'd16, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t3_overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("t3_drained_fill", 32'(fill_level), 32'd0);
    chk("t3_ovf_sticky",   32'(overflow),   32'd1);

    // Full with read and write in the same cycle: nothing is dropped.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 16'(i), 0, 0);
    step(0, 1, 16'd99, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("t4_fill", 32'(fill_level), 32'(DEPTH));
    chk("t4_ovf",  32'(overflow),   32'd0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("t4_empty", 32'(fill_level), 32'd0);

    // Back-to-back streaming across pointer wrap, then reset with data stored.
    for (int i = 0; i < 40; i++) step(0, 1, 16'($urandom), 1, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 16'($urandom), 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t5_fill5", 32'(fill_level), 32'd5);
    step(1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("t5_reset_fill",  32'(fill_level), 32'd0);
    chk("t5_reset_valid", 32'(m_tvalid),   32'd0);
    chk("t5_reset_data",  32'(m_tdata),    32'd0);

    // Peak tracking, including the saturated most-negative code.
    step(0, 1, 16'd100, 1, 0);
    step(0, 1, 16'h8000, 1, 0);
    step(0, 1, 16'd50, 1, 0);
    step(0, 0, 0, 1, 0);
`ifdef FIR_OUT_PEAK_EN
    chk("t6_peak_sat", 32'(peak_abs), 32'd32767);
`else
    chk("t6_peak_off", 32'(peak_abs), 32'd0);
`endif
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    chk("t6_peak_clr", 32'(peak_abs), 32'd0);
    step(0, 1, 16'hFFF9, 1, 0);
    step(0, 0, 0, 1, 0);
`ifdef FIR_OUT_PEAK_EN
    chk("t6_peak_neg7", 32'(peak_abs), 32'd7);
`else
    chk("t6_peak_neg7_off", 32'(peak_abs), 32'd0);
`endif

    // Randomized traffic with occasional peak clears and resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 9) < 7),
           16'($urandom),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 19) == 0));
    end

    // Drain everything; the scoreboard must end empty.
    for (int i = 0; i < DEPTH + 4; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("final_sb_empty", 32'(sb_q.size()), 32'd0);
    chk("final_fill",     32'(fill_level),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
